// File: rtl/mmss_display_pkg.sv
// Shared encodings and constants for the MM.SS seven-segment display driver.
package mmss_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CONV_S,
      ST_CONV_M,
      ST_HOLD
   } conv_state_t;

   typedef enum logic [1:0] {
      SLOT_SEC_ONES,
      SLOT_SEC_TENS,
      SLOT_MIN_ONES,
      SLOT_MIN_TENS
   } slot_t;

   // Segment patterns are active-low, bit 0 = segment a ... bit 6 = segment g.
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [5:0] MAX_VAL   = 6'd59;

   function automatic logic [6:0] digit_seg(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/mmss_display_if.sv
// Timer-to-display bundle: binary sec/min in, multiplexed anode/segment/dp pins out.
interface mmss_display_if;
   logic [5:0] sec;
   logic [5:0] min;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   modport master (output sec, min, input an, seg, dp);
   modport slave  (input sec, min, output an, seg, dp);
endinterface

// File: rtl/mmss_display_bin2bcd6.sv
// Iterative 6-bit binary to BCD: one subtract-10 per cycle, done pulses one cycle after the last step.
module bin2bcd6 (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [5:0] bin,
   output logic       busy,
   output logic       done,
   output logic [2:0] tens,
   output logic [3:0] ones
);

   logic [5:0] val;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         val  <= '0;
         tens <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            val  <= bin;
            tens <= '0;
            busy <= 1'b1;
         end else if (busy) begin
            if (val >= 6'd10) begin
               val  <= val - 6'd10;
               tens <= tens + 3'd1;
            end else begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   // Remainder is below ten once done, so only the low nibble carries the digit.
   assign ones = val[3:0];

endmodule

// File: rtl/mmss_display.sv
// Scans sec/min as MM.SS on a common-anode 4-digit display, snapshotting once per frame for tear-free digits.
// Optional COLON_BLINK_EN drives dp on the minutes-ones digit from the displayed seconds parity.
module mmss_display
   import mmss_pkg::*;
#(
   parameter int DIGIT_CYCLES = 2500
) (
   input  logic           clk,
   input  logic           reset,
   mmss_display_if.slave  bus
);

   localparam int CW = $clog2(DIGIT_CYCLES);

   logic [CW-1:0] cnt, cnt_nxt;
   slot_t         slot, slot_nxt;
   logic          tick, boundary;
   conv_state_t   state, state_nxt;

   logic       conv_start, conv_busy, conv_done;
   logic [5:0] conv_bin;
   logic [2:0] conv_tens;
   logic [3:0] conv_ones;

   logic [5:0] snap_min;
   logic       snap_inv_s, snap_inv_m;
   logic [2:0] hold_s_tens, hold_m_tens, disp_s_tens, disp_m_tens;
   logic [3:0] hold_s_ones, hold_m_ones, disp_s_ones, disp_m_ones;
   logic       disp_inv_s, disp_inv_m;

   logic [3:0] digit;
   logic       dash;

   assign tick     = (cnt == CW'(DIGIT_CYCLES - 1));
   assign cnt_nxt  = tick ? '0 : cnt + CW'(1);
   assign slot_nxt = tick ? slot_t'(slot + 2'd1) : slot;
   assign boundary = tick && (slot == SLOT_MIN_TENS);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt  <= '0;
         slot <= SLOT_SEC_ONES;
      end else begin
         cnt  <= cnt_nxt;
         slot <= slot_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Seconds are converted straight from the pins on the boundary cycle; that
   // start pulse is the seconds snapshot. Minutes follow from the snapshot register.
   always_comb begin
      state_nxt  = state;
      conv_start = 1'b0;
      conv_bin   = snap_min;
      if (boundary) begin
         state_nxt  = ST_CONV_S;
         conv_start = 1'b1;
         conv_bin   = bus.sec;
      end else begin
         case (state)
            ST_CONV_S: if (conv_done) begin
               state_nxt  = ST_CONV_M;
               conv_start = 1'b1;
            end
            ST_CONV_M: if (conv_done) state_nxt = ST_HOLD;
            default: ;
         endcase
      end
   end

   bin2bcd6 u_conv (
      .clk   (clk),
      .reset (reset),
      .start (conv_start),
      .bin   (conv_bin),
      .busy  (conv_busy),
      .done  (conv_done),
      .tens  (conv_tens),
      .ones  (conv_ones)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         snap_min    <= '0;
         snap_inv_s  <= 1'b0;
         snap_inv_m  <= 1'b0;
         hold_s_tens <= '0;
         hold_s_ones <= '0;
         hold_m_tens <= '0;
         hold_m_ones <= '0;
         disp_s_tens <= '0;
         disp_s_ones <= '0;
         disp_m_tens <= '0;
         disp_m_ones <= '0;
         disp_inv_s  <= 1'b0;
         disp_inv_m  <= 1'b0;
      end else begin
         if (boundary) begin
            disp_s_tens <= hold_s_tens;
            disp_s_ones <= hold_s_ones;
            disp_m_tens <= hold_m_tens;
            disp_m_ones <= hold_m_ones;
            disp_inv_s  <= snap_inv_s;
            disp_inv_m  <= snap_inv_m;
            snap_min    <= bus.min;
            snap_inv_s  <= (bus.sec > MAX_VAL);
            snap_inv_m  <= (bus.min > MAX_VAL);
         end
         if (state == ST_CONV_S && conv_done) begin
            hold_s_tens <= conv_tens;
            hold_s_ones <= conv_ones;
         end
         if (state == ST_CONV_M && conv_done) begin
            hold_m_tens <= conv_tens;
            hold_m_ones <= conv_ones;
         end
      end
   end

   // Display registers only change when cnt_nxt is 0 (blanked), so reading the
   // current values here never shows a half-committed frame.
   always_comb begin
      digit = '0;
      dash  = 1'b0;
      case (slot_nxt)
         SLOT_SEC_ONES: begin digit = disp_s_ones;         dash = disp_inv_s; end
         SLOT_SEC_TENS: begin digit = {1'b0, disp_s_tens}; dash = disp_inv_s; end
         SLOT_MIN_ONES: begin digit = disp_m_ones;         dash = disp_inv_m; end
         default:       begin digit = {1'b0, disp_m_tens}; dash = disp_inv_m; end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.an  <= 4'b1111;
         bus.seg <= SEG_BLANK;
      end else if (cnt_nxt == '0) begin
         bus.an  <= 4'b1111;
         bus.seg <= SEG_BLANK;
      end else begin
         bus.an  <= ~(4'b0001 << slot_nxt);
         bus.seg <= dash ? SEG_DASH : digit_seg(digit);
      end
   end

`ifdef COLON_BLINK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) bus.dp <= 1'b1;
      else       bus.dp <= !((cnt_nxt != '0) && (slot_nxt == SLOT_MIN_ONES) &&
                             !disp_inv_s && !disp_s_ones[0]);
   end
`else
   assign bus.dp = 1'b1;
`endif

   assert property (@(posedge clk) DIGIT_CYCLES >= 8);
   assert property (@(posedge clk) disable iff (reset) conv_done |-> !conv_busy);

endmodule

// File: tb/tb_mmss_display.sv
// Bench for mmss_display: a frame-level model queues snapshots at each boundary and compares every cycle.
module tb_mmss_display;

   localparam int DC    = 8;
   localparam int FRAME = 4 * DC;

   typedef struct packed {
      logic [5:0] s;
      logic [5:0] m;
   } val_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mmss_display_if bus ();

   mmss_display #(.DIGIT_CYCLES(DC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   val_t exp_q[$];
   val_t cur;
   int   cyc;
   int   compared   = 0;
   int   mismatched = 0;

   // Snapshot pushed when the boundary takes the inputs, popped one frame later when it is shown.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc = 0;
         exp_q.delete();
         exp_q.push_back('0);
         cur = '0;
      end else begin
         cyc++;
         if (cyc % FRAME == 0) begin
            cur = exp_q.pop_front();
            exp_q.push_back({bus.sec, bus.min});
         end
      end
   end

   function automatic logic [6:0] pat(input int d);
      case (d)
         0: return 7'b1000000;  1: return 7'b1111001;
         2: return 7'b0100100;  3: return 7'b0110000;
         4: return 7'b0011001;  5: return 7'b0010010;
         6: return 7'b0000010;  7: return 7'b1111000;
         8: return 7'b0000000;  9: return 7'b0010000;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic logic [3:0] exp_an();
      logic [3:0] r;
      r = 4'b1111;
      if (cyc % DC != 0) r[(cyc / DC) % 4] = 1'b0;
      return r;
   endfunction

   function automatic logic [6:0] exp_seg();
      int sl, v;
      sl = (cyc / DC) % 4;
      v  = (sl < 2) ? int'(cur.s) : int'(cur.m);
      if (v > 59) return 7'b0111111;
      return pat((sl % 2 == 0) ? v % 10 : v / 10);
   endfunction

   function automatic logic exp_dp();
`ifdef COLON_BLINK_EN
      if (cyc % DC != 0 && (cyc / DC) % 4 == 2 && cur.s <= 59 && cur.s % 2 == 0) return 1'b0;
`endif
      return 1'b1;
   endfunction

   task automatic align_boundary();
      @(negedge clk);
      for (int i = 0; i < FRAME && cyc % FRAME != 0; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      bus.sec = '0;
      bus.min = '0;
      reset   = 1'b1;
      repeat (3) begin
         @(negedge clk);
         compared++;
         if (bus.an !== 4'b1111 || bus.seg !== 7'h7F || bus.dp !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_outputs an=%b seg=%b dp=%b want 1111 1111111 1", bus.an, bus.seg, bus.dp);
         end
      end
      reset = 1'b0;
      repeat (2 * FRAME) begin
         @(negedge clk);
         compared++;
         if (bus.an !== exp_an()) begin
            mismatched++; $display("FAIL reset_an cyc=%0d got %b want %b", cyc, bus.an, exp_an());
         end
         if (cyc % DC != 0) begin
            compared++;
            if (bus.seg !== 7'b1000000) begin
               mismatched++; $display("FAIL reset_zero_seg cyc=%0d got %b want 1000000", cyc, bus.seg);
            end
         end
      end
   endtask

   task automatic test_hold();
      logic [6:0] tbl [4];
      tbl[0] = 7'b1111000; tbl[1] = 7'b0110000; tbl[2] = 7'b0100100; tbl[3] = 7'b1111001;
      bus.sec = 6'd37;
      bus.min = 6'd12;
      repeat (3 * FRAME) begin
         @(negedge clk);
         compared++;
         if (bus.an !== exp_an()) begin
            mismatched++; $display("FAIL hold_an cyc=%0d got %b want %b", cyc, bus.an, exp_an());
         end
         if (cyc % DC != 0) begin
            compared++;
            if (bus.seg !== exp_seg()) begin
               mismatched++; $display("FAIL hold_seg cyc=%0d got %b want %b", cyc, bus.seg, exp_seg());
            end
         end
         compared++;
         if (bus.dp !== exp_dp()) begin
            mismatched++; $display("FAIL hold_dp cyc=%0d got %b want %b", cyc, bus.dp, exp_dp());
         end
      end
      for (int s = 0; s < 4; s++) begin
         for (int i = 0; i < FRAME && cyc % FRAME != s * DC + 3; i++) @(negedge clk);
         compared++;
         if (bus.seg !== tbl[s] || bus.an[s] !== 1'b0) begin
            mismatched++; $display("FAIL hold_slot%0d seg=%b an=%b want seg %b", s, bus.seg, bus.an, tbl[s]);
         end
      end
   endtask

   task automatic test_input_change();
      align_boundary();
      bus.sec = 6'd5;
      bus.min = 6'd0;
      align_boundary();
      repeat (10) @(negedge clk);
      bus.sec = 6'd6;
      repeat (3 * FRAME) begin
         @(negedge clk);
         compared++;
         if (bus.an !== exp_an()) begin
            mismatched++; $display("FAIL change_an cyc=%0d got %b want %b", cyc, bus.an, exp_an());
         end
         if (cyc % DC != 0) begin
            compared++;
            if (bus.seg !== exp_seg()) begin
               mismatched++; $display("FAIL change_seg cyc=%0d got %b want %b", cyc, bus.seg, exp_seg());
            end
         end
      end
   endtask

   task automatic test_out_of_range();
      bus.sec = 6'd60;
      bus.min = 6'd63;
      repeat (3 * FRAME) begin
         @(negedge clk);
         compared++;
         if (bus.an !== exp_an()) begin
            mismatched++; $display("FAIL range_an cyc=%0d got %b want %b", cyc, bus.an, exp_an());
         end
         if (cyc % DC != 0) begin
            compared++;
            if (bus.seg !== exp_seg()) begin
               mismatched++; $display("FAIL range_seg cyc=%0d got %b want %b", cyc, bus.seg, exp_seg());
            end
         end
         compared++;
         if (bus.dp !== exp_dp()) begin
            mismatched++; $display("FAIL range_dp cyc=%0d got %b want %b", cyc, bus.dp, exp_dp());
         end
      end
   endtask

   task automatic test_colon();
      logic [5:0] vals [2];
      vals[0] = 6'd4;
      vals[1] = 6'd5;
      for (int k = 0; k < 2; k++) begin
         bus.sec = vals[k];
         bus.min = 6'd30;
         repeat (3 * FRAME) begin
            @(negedge clk);
            compared++;
            if (bus.dp !== exp_dp()) begin
               mismatched++; $display("FAIL colon_dp sec=%0d cyc=%0d got %b want %b", vals[k], cyc, bus.dp, exp_dp());
            end
            if (cyc % DC != 0) begin
               compared++;
               if (bus.seg !== exp_seg()) begin
                  mismatched++; $display("FAIL colon_seg cyc=%0d got %b want %b", cyc, bus.seg, exp_seg());
               end
            end
         end
      end
   endtask

   task automatic test_reset_mid_conv();
      bus.sec = 6'd21;
      bus.min = 6'd45;
      align_boundary();
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      compared++;
      if (bus.an !== 4'b1111 || bus.seg !== 7'h7F || bus.dp !== 1'b1) begin
         mismatched++;
         $display("FAIL midreset_blank an=%b seg=%b dp=%b want 1111 1111111 1", bus.an, bus.seg, bus.dp);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3 * FRAME) begin
         @(negedge clk);
         compared++;
         if (bus.an !== exp_an()) begin
            mismatched++; $display("FAIL midreset_an cyc=%0d got %b want %b", cyc, bus.an, exp_an());
         end
         if (cyc % DC != 0) begin
            compared++;
            if (bus.seg !== exp_seg()) begin
               mismatched++; $display("FAIL midreset_seg cyc=%0d got %b want %b", cyc, bus.seg, exp_seg());
            end
         end
         compared++;
         if (bus.dp !== exp_dp()) begin
            mismatched++; $display("FAIL midreset_dp cyc=%0d got %b want %b", cyc, bus.dp, exp_dp());
         end
      end
   endtask

   initial begin
      test_reset();
      test_hold();
      test_input_change();
      test_out_of_range();
      test_colon();
      test_reset_mid_conv();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
